// File: rtl/timer_set_datapath_pkg.sv
// Shared constants for the timer-set controller/datapath pair.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: bus source select codes, controller state code that clears K,
//           and default datapath widths.
package timer_pkg;

  localparam int DW_DEF   = 4;
  localparam int KW_DEF   = 3;
  localparam int KMAX_DEF = 7;

  localparam logic [1:0] SEL_DIN  = 2'd0;
  localparam logic [1:0] SEL_SUM  = 2'd1;
  localparam logic [1:0] SEL_K    = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  localparam logic [3:0] ST_IDLE_WAIT = 4'd1;

endpackage

// File: rtl/timer_set_datapath_if.sv
// Control word from the timer-set controller plus the status it branches on.
// Latency: n/a (wires only).
// Backpressure: none; the control word is valid every cycle.
// Signals: T (state echo), s (bus select), Kc, La, Lb, Ea, Lr, Er (controls);
//          t, k7 (status returned to the controller).
interface timer_set_datapath_if;

  logic [3:0] T;
  logic [1:0] s;
  logic       Kc;
  logic       La;
  logic       Lb;
  logic       Ea;
  logic       Lr;
  logic       Er;
  logic       t;
  logic       k7;

  modport master (output T, s, Kc, La, Lb, Ea, Lr, Er, input t, k7);
  modport slave  (input T, s, Kc, La, Lb, Ea, Lr, Er, output t, k7);

endinterface

// File: rtl/timer_set_datapath_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus a rising-edge pulse.
// Latency: pulse is high in the cycle after the 2nd capturing edge.
// Backpressure: none; one-cycle pulse per press edge.
// Ports: clk, rst_n, btn_i (raw async level), pulse_o (one-cycle pulse).
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/timer_set_datapath.sv
// Register-transfer datapath executing the timer-set controller's control word.
// Latency: loads/counter/t update 1 clock after the control word; k7 is comb from K.
// Backpressure: none; any control combination is accepted every cycle.
// Ports: clk, rst_n; ctl (control word in, t/k7 status out); din (switch digit);
//        btn_set (raw button); timer_val (R); sum_ovf (carry of last A+B load).
module timer_set_datapath
  import timer_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int KW   = KW_DEF,
  parameter int KMAX = KMAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  timer_set_datapath_if.slave     ctl,
  input  logic [DW-1:0]           din,
  input  logic                    btn_set,
  output logic [DW-1:0]           timer_val,
  output logic                    sum_ovf
);

  localparam int KC = (DW < KW) ? DW : KW;

  logic [DW-1:0] a_q, b_q, r_q;
  logic [KW-1:0] k_q, k_d;
  logic          t_q, t_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] bus;
  logic [DW:0]   sum_full;
  logic [DW-1:0] k_ext;
  logic          bus_is_sum;
  logic          any_load;
  logic          set_pulse;

  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    k_ext         = '0;
    k_ext[KC-1:0] = k_q[KC-1:0];
  end

  // Er beats Ea beats the s-selected source.
  always_comb begin
    bus        = '0;
    bus_is_sum = 1'b0;
    if (ctl.Er) begin
      bus = r_q;
    end else if (ctl.Ea) begin
      bus = a_q;
    end else begin
      case (ctl.s)
        SEL_DIN:  bus = din;
        SEL_SUM:  begin
          bus        = sum_full[DW-1:0];
          bus_is_sum = 1'b1;
        end
        SEL_K:    bus = k_ext;
        default:  bus = '0;
      endcase
    end
  end

  assign any_load = ctl.La | ctl.Lb | ctl.Lr;

  // Carry is only meaningful when a sum is actually being stored somewhere.
  always_comb begin
    ovf_d = ovf_q;
    if (bus_is_sum && any_load) ovf_d = sum_full[DW];
  end

  always_comb begin
    k_d = k_q;
    if (ctl.T == ST_IDLE_WAIT) begin
      k_d = '0;
    end else if (ctl.Kc) begin
      k_d = (k_q == KW'(KMAX)) ? '0 : k_q + KW'(1);
    end
  end

  // A new press wins over the consume so a press landing on Kc is not lost.
  always_comb begin
    t_d = t_q;
    if (set_pulse)   t_d = 1'b1;
    else if (ctl.Kc) t_d = 1'b0;
  end

  btn_sync_edge u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_set),
    .pulse_o (set_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      k_q   <= '0;
      t_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (ctl.La) a_q <= bus;
      if (ctl.Lb) b_q <= bus;
      if (ctl.Lr) r_q <= bus;
      k_q   <= k_d;
      t_q   <= t_d;
      ovf_q <= ovf_d;
    end
  end

  assign ctl.t     = t_q;
  assign ctl.k7    = (k_q == KW'(KMAX));
  assign timer_val = r_q;
  assign sum_ovf   = ovf_q;

endmodule
